// File: rtl/fifo_pkg.sv
// Shared FIFO constants and helpers. Imported by fifo_dpram and sync_fifo_buffer.
package fifo_pkg;

    // Default word width and depth used by the FIFO blocks.
    localparam int FIFO_DEF_DATA_WIDTH = 8;
    localparam int FIFO_DEF_DEPTH      = 8;

    // Width of a pointer that carries a wrap bit above the memory address.
    function automatic int fifo_ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_dpram.sv
// Dual-port storage array for the FIFO: synchronous write port and a
// registered read port whose output register clears on rst.
// Memory contents are deliberately left out of reset so the array maps to block RAM.
module fifo_dpram
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DEF_DATA_WIDTH,
    parameter int DEPTH      = FIFO_DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_WIDTH-1:0]    wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_WIDTH-1:0]    rdata
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Write port: store the word at the accepting edge.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Read port: load the addressed word on an accepted read, otherwise hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/sync_fifo_buffer.sv
// Single-clock FIFO queue: wrap-bit pointers, registered occupancy count,
// registered full/empty/almost flags and optional sticky error flags.
// Optional feature macro: SYNC_FIFO_ERR_FLAGS_EN enables overflow/underflow
// tracking; when undefined both flags read 0 and err_clr is ignored.
module sync_fifo_buffer
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DEF_DATA_WIDTH,
    parameter int DEPTH      = FIFO_DEF_DEPTH,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int AFULL_LVL  = DEPTH - 2,
    parameter int AEMPTY_LVL = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  w_inc,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  r_inc,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  err_clr
);

    localparam int             PTR_W    = fifo_ptr_w(DEPTH);
    localparam logic [PTR_W-1:0] ONE_C    = PTR_W'(1);
    localparam logic [PTR_W-1:0] DEPTH_C  = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0] AFULL_C  = PTR_W'(AFULL_LVL);
    localparam logic [PTR_W-1:0] AEMPTY_C = PTR_W'(AEMPTY_LVL);

    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [PTR_W-1:0] count_q, count_d;
    logic             full_q, empty_q, afull_q, aempty_q;
    logic             write_acc, read_acc;

    // Accept decisions use the flags registered at the current edge, so a
    // read can never target the slot being written in the same cycle.
    always_comb begin
        write_acc = w_inc && !full_q;
        read_acc  = r_inc && !empty_q;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        count_d   = count_q;
        if (write_acc) begin
            wptr_d = wptr_q + ONE_C;
        end
        if (read_acc) begin
            rptr_d = rptr_q + ONE_C;
        end
        case ({write_acc, read_acc})
            2'b10:   count_d = count_q + ONE_C;
            2'b01:   count_d = count_q - ONE_C;
            default: count_d = count_q;
        endcase
    end

    // Pointer, count and flag registers; flags derive from the next count so
    // they change on the same edge as the pointers and never glitch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            full_q   <= (count_d == DEPTH_C);
            empty_q  <= (count_d == '0);
            afull_q  <= (count_d >= AFULL_C);
            aempty_q <= (count_d <= AEMPTY_C);
        end
    end

    fifo_dpram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (write_acc),
        .waddr (wptr_q[PTR_W-2:0]),
        .wdata (write_data),
        .re    (read_acc),
        .raddr (rptr_q[PTR_W-2:0]),
        .rdata (read_data)
    );

    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = afull_q;
    assign almost_empty = aempty_q;
    assign count        = count_q;

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic overflow_q, underflow_q;

    // Sticky error flags; a new error in the clearing cycle keeps the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= (overflow_q  && !err_clr) || (w_inc && full_q);
            underflow_q <= (underflow_q && !err_clr) || (r_inc && empty_q);
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`else
    // Error tracking compiled out; ports kept so integration does not change.
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign overflow       = 1'b0;
    assign underflow      = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo_buffer.sv
// Scoreboard bench for sync_fifo_buffer: the driver updates a queue-based
// reference model and pushes the expected post-edge state; a monitor pops
// and compares after every rising edge that follows a driven cycle.
module tb_sync_fifo_buffer;

    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int AW    = $clog2(DEPTH);

    logic          clk;
    logic          rst;
    logic          w_inc;
    logic [DW-1:0] write_data;
    logic          r_inc;
    logic [DW-1:0] read_data;
    logic          full, empty, almost_full, almost_empty;
    logic [AW:0]   count;
    logic          overflow, underflow;
    logic          err_clr;

    sync_fifo_buffer #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .w_inc        (w_inc),
        .write_data   (write_data),
        .r_inc        (r_inc),
        .read_data    (read_data),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow),
        .err_clr      (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int cnt;
        int rd;
        bit full;
        bit empty;
        bit af;
        bit ae;
        bit ovf;
        bit unf;
    } exp_t;

    exp_t    exp_q[$];
    int      model_q[$];
    int      m_rd;
    bit      m_ovf, m_unf;
    int      n_cmp = 0;
    int      n_err = 0;
    int      n_txn = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected state from the queue model, using the rules on occupancy only.
    function automatic exp_t model_snapshot();
        exp_t e;
        e.cnt   = model_q.size();
        e.rd    = m_rd;
        e.full  = (model_q.size() == DEPTH);
        e.empty = (model_q.size() == 0);
        e.af    = (model_q.size() >= DEPTH - 2);
        e.ae    = (model_q.size() <= 2);
        e.ovf   = m_ovf;
        e.unf   = m_unf;
        return e;
    endfunction

    // One clock of stimulus: drive at negedge, advance model, queue expectation.
    task automatic drive(input bit w, input bit r, input logic [DW-1:0] d, input bit c);
        bit was_full, was_empty;
        @(negedge clk);
        w_inc      = w;
        r_inc      = r;
        write_data = d;
        err_clr    = c;
        was_full   = (model_q.size() == DEPTH);
        was_empty  = (model_q.size() == 0);
        if (r && !was_empty) m_rd = model_q.pop_front();
        if (w && !was_full)  model_q.push_back(int'(d));
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        m_ovf = (m_ovf && !c) || (w && was_full);
        m_unf = (m_unf && !c) || (r && was_empty);
`else
        m_ovf = 1'b0;
        m_unf = 1'b0;
`endif
        exp_q.push_back(model_snapshot());
    endtask

    task automatic model_reset();
        model_q.delete();
        m_rd  = 0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_count"},        32'(count), 0);
        chk({tag, "_empty"},        32'(empty), 1);
        chk({tag, "_almost_empty"}, 32'(almost_empty), 1);
        chk({tag, "_full"},         32'(full), 0);
        chk({tag, "_almost_full"},  32'(almost_full), 0);
        chk({tag, "_read_data"},    32'(read_data), 0);
        chk({tag, "_overflow"},     32'(overflow), 0);
        chk({tag, "_underflow"},    32'(underflow), 0);
    endtask

    // Monitor: after each rising edge, compare outputs to the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_txn++;
                chk("count",        32'(count), 32'(e.cnt));
                chk("read_data",    32'(read_data), 32'(e.rd));
                chk("full",         32'(full), 32'(e.full));
                chk("empty",        32'(empty), 32'(e.empty));
                chk("almost_full",  32'(almost_full), 32'(e.af));
                chk("almost_empty", 32'(almost_empty), 32'(e.ae));
                chk("overflow",     32'(overflow), 32'(e.ovf));
                chk("underflow",    32'(underflow), 32'(e.unf));
                $display("txn %0d: w=%0b r=%0b wd=%02h -> count=%0d rd=%02h full=%0b empty=%0b af=%0b ae=%0b ovf=%0b unf=%0b",
                         n_txn, w_inc, r_inc, write_data, count, read_data, full, empty,
                         almost_full, almost_empty, overflow, underflow);
            end
        end
    end

    // Watchdog: the run must end on its own.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    int unsigned wpct [5] = '{50, 85, 20, 95, 60};
    int unsigned rpct [5] = '{50, 20, 85, 95, 60};

    initial begin
        logic [DW-1:0] v;
        w_inc      = 1'b0;
        r_inc      = 1'b0;
        write_data = '0;
        err_clr    = 1'b0;
        rst        = 1'b0;
        model_reset();
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1 check_reset_state("reset");

        // Fill with 0x11..0x88, then drain in order.
        for (int i = 1; i <= DEPTH; i++) begin
            v = DW'(i * 8'h11);
            drive(1'b1, 1'b0, v, 1'b0);
        end
        for (int i = 0; i < DEPTH; i++) drive(1'b0, 1'b1, 8'h00, 1'b0);

        // Wrap-around: write 5, read 5, write 8, read 8.
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, DW'($urandom), 1'b0);
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 8'h00, 1'b0);
        for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, DW'($urandom), 1'b0);
        for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, 8'h00, 1'b0);

        // Full with both requests, then write while full (overflow), then clear.
        for (int i = 0; i < DEPTH; i++) drive(1'b1, 1'b0, DW'($urandom), 1'b0);
        drive(1'b1, 1'b1, 8'hEE, 1'b0);
        drive(1'b1, 1'b0, 8'hEF, 1'b0);
        drive(1'b1, 1'b0, 8'hDD, 1'b0);
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        drive(1'b1, 1'b0, 8'hDE, 1'b1);
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < DEPTH; i++) drive(1'b0, 1'b1, 8'h00, 1'b0);

        // Read while empty (underflow, read_data held), empty with both, clear.
        drive(1'b0, 1'b1, 8'h00, 1'b0);
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        drive(1'b1, 1'b1, 8'h3C, 1'b0);
        drive(1'b0, 1'b0, 8'h00, 1'b1);

        // Half-full with simultaneous requests.
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, DW'($urandom), 1'b0);
        for (int i = 0; i < 6; i++) drive(1'b1, 1'b1, DW'($urandom), 1'b0);

        // Randomised phases with varying write/read pressure.
        for (int p = 0; p < 5; p++) begin
            for (int i = 0; i < 120; i++) begin
                drive($urandom_range(99) < wpct[p], $urandom_range(99) < rpct[p],
                      DW'($urandom), $urandom_range(99) < 8);
            end
        end

        // Drain, bring count to 4, then assert reset between edges.
        for (int i = 0; i < DEPTH + 1; i++) drive(1'b0, 1'b1, 8'h00, 1'b0);
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, DW'(8'h60 + i), 1'b0);
        @(negedge clk);
        w_inc = 1'b0;
        r_inc = 1'b0;
        err_clr = 1'b0;
        #1;
        chk("pre_reset_count", 32'(count), 4);
        #1 rst = 1'b1;
        #1;
        model_reset();
        check_reset_state("async_reset");
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 1'b0, 8'hA5, 1'b0);
        drive(1'b0, 1'b1, 8'h00, 1'b0);
        drive(1'b0, 1'b0, 8'h00, 1'b0);

        repeat (2) @(posedge clk);
        #2;
        chk("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
